// File: rtl/icap_config_reader_if.sv
// ---------------------------------------------------------------------------
// icap_config_reader_if
//
// Bundles the host-side request/response handshake and the ICAP_SPARTAN6 pin
// group of the configuration readback engine.
//
// Host side : start, reg_addr (to reader); busy, done, error, data (from reader)
// ICAP side : icap_clk, icap_ce, icap_write, icap_i (to primitive);
//             icap_o, icap_busy (from primitive)
//
// slave  - the reader itself
// master - whoever issues requests and models/owns the ICAP primitive
// ---------------------------------------------------------------------------
interface icap_config_reader_if;
    logic        start;
    logic [5:0]  reg_addr;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] data;
    logic        icap_clk;
    logic        icap_ce;
    logic        icap_write;
    logic [15:0] icap_i;
    logic [15:0] icap_o;
    logic        icap_busy;

    modport slave (
        input  start, reg_addr, icap_o, icap_busy,
        output busy, done, error, data, icap_clk, icap_ce, icap_write, icap_i
    );

    modport master (
        output start, reg_addr, icap_o, icap_busy,
        input  busy, done, error, data, icap_clk, icap_ce, icap_write, icap_i
    );
endinterface

// File: rtl/icap_config_reader.sv
// ---------------------------------------------------------------------------
// icap_config_reader
//
// Reads one 16-bit Spartan-6 configuration register through ICAP: syncs the
// configuration logic, issues a Type-1 one-word read header, turns the bus
// around, captures the returned word, turns the bus back and desyncs.
//
// Ports:
//   clock    system clock
//   reset    synchronous, active-high reset
//   bus      icap_config_reader_if.slave
//              start/reg_addr   request (start honoured only while idle)
//              busy/done/error  status; done is a one-clock pulse, error
//                               (BUSY timeout) is valid with done
//              data             register value, held until the next request
//              icap_*           ICAP_SPARTAN6 pins (I/O words bit-reversed
//                               within each byte)
//
// Parameters:
//   CLK_DIV  system clocks per ICAP clock period (even, >= 2)
//   TIMEOUT  ICAP periods to wait for icap_busy low before giving up
// ---------------------------------------------------------------------------
module icap_config_reader #(
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    icap_config_reader_if.slave  bus
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_DUMMY, S_SYNC1, S_SYNC2, S_NOOP_A, S_RDHDR, S_NOOP_B,
        S_NOOP_C, S_TURN1, S_TURN2, S_RDWAIT, S_TURN3, S_TURN4, S_DSHDR,
        S_DSCMD, S_DSNOOP0, S_DSNOOP1, S_FIN
    } state_t;

    // Fixed step order; RDWAIT only leaves when the read resolves, IDLE only
    // when a request is pending, so those two are gated by the FSM.
    function automatic state_t seqNext(input state_t s);
        case (s)
            S_IDLE:    return S_DUMMY;
            S_DUMMY:   return S_SYNC1;
            S_SYNC1:   return S_SYNC2;
            S_SYNC2:   return S_NOOP_A;
            S_NOOP_A:  return S_RDHDR;
            S_RDHDR:   return S_NOOP_B;
            S_NOOP_B:  return S_NOOP_C;
            S_NOOP_C:  return S_TURN1;
            S_TURN1:   return S_TURN2;
            S_TURN2:   return S_RDWAIT;
            S_RDWAIT:  return S_TURN3;
            S_TURN3:   return S_TURN4;
            S_TURN4:   return S_DSHDR;
            S_DSHDR:   return S_DSCMD;
            S_DSCMD:   return S_DSNOOP0;
            S_DSNOOP0: return S_DSNOOP1;
            S_DSNOOP1: return S_FIN;
            default:   return S_IDLE;
        endcase
    endfunction

    // {ce, write, logical word} presented on the ICAP during each step.
    // The TURN steps move CE and WRITE one at a time so the primitive never
    // sees the read/write direction change while it is selected.
    function automatic logic [17:0] stepOut(input state_t s, input logic [5:0] addr);
        case (s)
            S_DUMMY:   return {2'b00, 16'hFFFF};
            S_SYNC1:   return {2'b00, 16'hAA99};
            S_SYNC2:   return {2'b00, 16'h5566};
            S_RDHDR:   return {2'b00, 16'h2801 | {5'd0, addr, 5'd0}};
            S_TURN1:   return {2'b10, 16'h2000};
            S_TURN2:   return {2'b11, 16'h2000};
            S_RDWAIT:  return {2'b01, 16'h2000};
            S_TURN3:   return {2'b11, 16'h2000};
            S_TURN4:   return {2'b10, 16'h2000};
            S_DSHDR:   return {2'b00, 16'h30A1};
            S_DSCMD:   return {2'b00, 16'h000D};
            S_NOOP_A, S_NOOP_B, S_NOOP_C, S_DSNOOP0, S_DSNOOP1:
                       return {2'b00, 16'h2000};
            default:   return {2'b11, 16'hFFFF};
        endcase
    endfunction

    // ICAP data pins carry each byte MSB-first on the low pin; the same
    // permutation converts in both directions.
    function automatic logic [15:0] swapBits(input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k]     = w[7 - k];
            r[8 + k] = w[15 - k];
        end
        return r;
    endfunction

    state_t            r_state;
    logic [DIV_W-1:0]  r_divCnt;
    logic              r_icapClk;
    logic [TO_W-1:0]   r_waitCnt;
    logic [5:0]        r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_data;
    logic              r_ce;
    logic              r_write;
    logic [15:0]       r_word;

    logic              w_tick;
    logic [DIV_W-1:0]  w_divNext;
    state_t            w_nextState;
    logic [17:0]       w_nextOut;

    // w_tick is both the sample point (after the ICAP rising edge) and the
    // clock on which the divider wraps, i.e. the ICAP falling edge.
    assign w_tick      = (r_divCnt == DIV_LAST);
    assign w_divNext   = w_tick ? '0 : r_divCnt + 1'b1;
    assign w_nextState = seqNext(r_state);
    assign w_nextOut   = stepOut(w_nextState, r_addr);

    // Divider, request handshake and step FSM. The ICAP outputs are only
    // reloaded on w_tick, giving half an ICAP period of setup and hold
    // around the primitive's rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_divCnt  <= '0;
            r_icapClk <= 1'b0;
            r_waitCnt <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_data    <= '0;
            r_ce      <= 1'b1;
            r_write   <= 1'b1;
            r_word    <= 16'hFFFF;
        end else begin
            r_divCnt  <= w_divNext;
            r_icapClk <= (w_divNext >= DIV_HALF);
            r_done    <= 1'b0;

            // r_done blocks a start on the clock right after completion.
            if (r_state == S_IDLE && !r_busy && !r_done && bus.start) begin
                r_addr  <= bus.reg_addr;
                r_busy  <= 1'b1;
                r_error <= 1'b0;
            end

            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_busy) begin
                            r_state                  <= w_nextState;
                            {r_ce, r_write, r_word}  <= w_nextOut;
                        end
                    end
                    S_RDWAIT: begin
                        if (!bus.icap_busy) begin
                            r_data                   <= swapBits(bus.icap_o);
                            r_state                  <= w_nextState;
                            {r_ce, r_write, r_word}  <= w_nextOut;
                        end else if (r_waitCnt == TO_LAST) begin
                            r_error                  <= 1'b1;
                            r_state                  <= w_nextState;
                            {r_ce, r_write, r_word}  <= w_nextOut;
                        end else begin
                            r_waitCnt <= r_waitCnt + 1'b1;
                        end
                    end
                    S_FIN: begin
                        r_done                   <= 1'b1;
                        r_busy                   <= 1'b0;
                        r_state                  <= w_nextState;
                        {r_ce, r_write, r_word}  <= w_nextOut;
                    end
                    default: begin
                        r_waitCnt                <= '0;
                        r_state                  <= w_nextState;
                        {r_ce, r_write, r_word}  <= w_nextOut;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.data       = r_data;
    assign bus.icap_clk   = r_icapClk;
    assign bus.icap_ce    = r_ce;
    assign bus.icap_write = r_write;
    assign bus.icap_i     = swapBits(r_word);

endmodule

// File: tb/tb_icap_config_reader.sv
// ---------------------------------------------------------------------------
// tb_icap_config_reader
//
// Directed bench for icap_config_reader (CLK_DIV=4, TIMEOUT=8). A small ICAP
// model answers reads, a logger records every non-idle ICAP step, and a pin
// monitor watches when the ICAP outputs are allowed to move.
// ---------------------------------------------------------------------------
module tb_icap_config_reader;

    logic clock;
    logic reset;

    icap_config_reader_if bus();

    icap_config_reader #(
        .CLK_DIV (4),
        .TIMEOUT (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checkCount;
    int          passCount;
    int          monChecks;
    int          monPasses;
    int          busyLeft;
    int          rdCount;
    int          logBase;
    bit          monEn;
    bit          gotDone;
    logic [15:0] doneData;
    logic        doneError;
    logic        doneBusy;
    logic [17:0] stepLog[$];
    logic [15:0] rawLog[$];
    logic [17:0] monPrev;
    logic [17:0] monCur;
    logic        monPrevClk;
    int          bad;

    // 100 MHz system clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k]     = w[7 - k];
            r[8 + k] = w[15 - k];
        end
        return r;
    endfunction

    // Expected {ce, write, logical word} for step idx of a read of addr that
    // spends nWait extra steps in the read-wait state.
    function automatic logic [17:0] expectedStep(input int idx, input logic [5:0] addr, input int nWait);
        int b;
        b = idx;
        if (idx > 9) b = (idx <= 9 + nWait) ? 9 : idx - nWait;
        case (b)
            0:  return {2'b00, 16'hFFFF};
            1:  return {2'b00, 16'hAA99};
            2:  return {2'b00, 16'h5566};
            4:  return {2'b00, 16'h2801 | (16'(addr) << 5)};
            7:  return {2'b10, 16'h2000};
            8:  return {2'b11, 16'h2000};
            9:  return {2'b01, 16'h2000};
            10: return {2'b11, 16'h2000};
            11: return {2'b10, 16'h2000};
            12: return {2'b00, 16'h30A1};
            13: return {2'b00, 16'h000D};
            default: return {2'b00, 16'h2000};
        endcase
    endfunction

    function automatic int firstSeqMismatch(input logic [5:0] addr, input int nWait);
        int n;
        n = stepLog.size() - logBase;
        if (n != 16 + nWait) return n;
        for (int i = 0; i < n; i++)
            if (stepLog[logBase + i] !== expectedStep(i, addr, nWait)) return i;
        return -1;
    endfunction

    // ICAP model: during read steps holds BUSY high for busyLeft ICAP rising
    // edges, then low; icap_o is whatever the current test placed there.
    initial begin
        bus.icap_busy = 1'b1;
        rdCount = 0;
        forever begin
            @(posedge bus.icap_clk);
            if (bus.icap_ce === 1'b0 && bus.icap_write === 1'b1) begin
                bus.icap_busy = (rdCount < busyLeft);
                rdCount++;
            end else begin
                bus.icap_busy = 1'b1;
                rdCount = 0;
            end
        end
    end

    // Step logger: one entry per ICAP rising edge, skipping idle steps.
    initial begin
        forever begin
            @(posedge bus.icap_clk);
            if (!(bus.icap_ce === 1'b1 && bus.icap_write === 1'b1 && bus.icap_i === 16'hFFFF)) begin
                stepLog.push_back({bus.icap_ce, bus.icap_write, rev16(bus.icap_i)});
                rawLog.push_back(bus.icap_i);
            end
        end
    end

    // Pin monitor: outputs may only move across an ICAP falling edge, and
    // away from the idle pattern CE and WRITE never move together.
    initial begin
        monChecks  = 0;
        monPasses  = 0;
        monPrev    = {2'b11, 16'hFFFF};
        monPrevClk = 1'b0;
        forever begin
            @(negedge clock);
            monCur = {bus.icap_ce, bus.icap_write, bus.icap_i};
            if (monEn && monCur !== monPrev) begin
                monChecks++;
                if (!(monPrevClk === 1'b1 && bus.icap_clk === 1'b0))
                    $display("[TB] FAIL pin_edge: outputs %h -> %h with icap_clk %b -> %b, required change only on falling edge",
                             monPrev, monCur, monPrevClk, bus.icap_clk);
                else
                    monPasses++;
                if (monPrev !== {2'b11, 16'hFFFF} && monCur !== {2'b11, 16'hFFFF}) begin
                    monChecks++;
                    if (monPrev[17] !== monCur[17] && monPrev[16] !== monCur[16])
                        $display("[TB] FAIL ce_write_turn: ce/write %b -> %b, required at most one to change",
                                 monPrev[17:16], monCur[17:16]);
                    else
                        monPasses++;
                end
            end
            monPrev    = monCur;
            monPrevClk = bus.icap_clk;
        end
    end

    task automatic waitDone(output bit got);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [5:0] addr, input logic [15:0] pins, input int nBusy);
        bus.reg_addr = addr;
        bus.icap_o   = pins;
        busyLeft     = nBusy;
        @(negedge clock);
        logBase   = stepLog.size();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        waitDone(gotDone);
        doneData  = bus.data;
        doneError = bus.error;
        doneBusy  = bus.busy;
    endtask

    task automatic test_reset;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passCount++;
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passCount++;
        checkCount++;
        if (bus.error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", bus.error); else passCount++;
        checkCount++;
        if (bus.data !== 16'h0000) $display("[TB] FAIL reset_data: got %h expected 0000", bus.data); else passCount++;
        checkCount++;
        if ({bus.icap_ce, bus.icap_write} !== 2'b11) $display("[TB] FAIL reset_ce_write: got %b expected 11", {bus.icap_ce, bus.icap_write}); else passCount++;
        checkCount++;
        if (bus.icap_i !== 16'hFFFF) $display("[TB] FAIL reset_icap_i: got %h expected ffff", bus.icap_i); else passCount++;
        checkCount++;
        if (bus.icap_clk !== 1'b0) $display("[TB] FAIL reset_icap_clk: got %b expected 0", bus.icap_clk); else passCount++;
    endtask

    task automatic test_basic_read;
        applyStimulus(6'h17, 16'h0080, 0);
        checkCount++;
        if (!gotDone) $display("[TB] FAIL basic_done: no done within bound, expected done pulse"); else passCount++;
        checkCount++;
        if (doneData !== 16'h0001) $display("[TB] FAIL basic_data: got %h expected 0001", doneData); else passCount++;
        checkCount++;
        if (doneError !== 1'b0) $display("[TB] FAIL basic_error: got %b expected 0", doneError); else passCount++;
        checkCount++;
        if (doneBusy !== 1'b0) $display("[TB] FAIL basic_busy_at_done: got %b expected 0", doneBusy); else passCount++;
        checkCount++;
        if (stepLog.size() - logBase !== 16) $display("[TB] FAIL basic_len: got %0d steps expected 16", stepLog.size() - logBase); else passCount++;
        bad = firstSeqMismatch(6'h17, 0);
        checkCount++;
        if (bad !== -1) $display("[TB] FAIL basic_seq: step %0d got %h expected %h", bad, stepLog[logBase + bad], expectedStep(bad, 6'h17, 0)); else passCount++;
    endtask

    task automatic test_bit_reversal;
        applyStimulus(6'h17, 16'h0180, 0);
        checkCount++;
        if (!gotDone || doneData !== 16'h8001) $display("[TB] FAIL rev_data: got %h (done %b) expected 8001", doneData, gotDone); else passCount++;
        checkCount++;
        if (rawLog[logBase + 4] !== 16'h5487) $display("[TB] FAIL rev_rdhdr_pins: got %h expected 5487", rawLog[logBase + 4]); else passCount++;
        checkCount++;
        if (rawLog[logBase + 1] !== 16'h5599) $display("[TB] FAIL rev_sync_pins: got %h expected 5599", rawLog[logBase + 1]); else passCount++;
    endtask

    task automatic test_busy_wait;
        applyStimulus(6'h09, 16'h037B, 5);
        checkCount++;
        if (!gotDone || doneData !== 16'hC0DE) $display("[TB] FAIL wait_data: got %h (done %b) expected c0de", doneData, gotDone); else passCount++;
        checkCount++;
        if (doneError !== 1'b0) $display("[TB] FAIL wait_error: got %b expected 0", doneError); else passCount++;
        checkCount++;
        if (stepLog.size() - logBase !== 21) $display("[TB] FAIL wait_len: got %0d steps expected 21", stepLog.size() - logBase); else passCount++;
        bad = firstSeqMismatch(6'h09, 5);
        checkCount++;
        if (bad !== -1) $display("[TB] FAIL wait_seq: step %0d got %h expected %h", bad, stepLog[logBase + bad], expectedStep(bad, 6'h09, 5)); else passCount++;
    endtask

    task automatic test_timeout;
        applyStimulus(6'h0A, 16'h1234, 1000);
        checkCount++;
        if (!gotDone || doneError !== 1'b1) $display("[TB] FAIL timeout_error: got %b (done %b) expected 1", doneError, gotDone); else passCount++;
        checkCount++;
        if (doneData !== 16'hC0DE) $display("[TB] FAIL timeout_data_kept: got %h expected c0de", doneData); else passCount++;
        checkCount++;
        if (stepLog[logBase + 19] !== {2'b00, 16'h30A1}) $display("[TB] FAIL timeout_dshdr: got %h expected 030a1", stepLog[logBase + 19]); else passCount++;
        checkCount++;
        if (stepLog[logBase + 20] !== {2'b00, 16'h000D}) $display("[TB] FAIL timeout_dscmd: got %h expected 0000d", stepLog[logBase + 20]); else passCount++;
        bad = firstSeqMismatch(6'h0A, 7);
        checkCount++;
        if (bad !== -1) $display("[TB] FAIL timeout_seq: step %0d got %h expected %h", bad, stepLog[logBase + bad], expectedStep(bad, 6'h0A, 7)); else passCount++;
    endtask

    task automatic test_back_to_back;
        bus.reg_addr = 6'h17;
        bus.icap_o   = 16'h8888;
        busyLeft     = 0;
        @(negedge clock);
        bus.start = 1'b1;
        waitDone(gotDone);
        checkCount++;
        if (!gotDone || bus.data !== 16'h1111 || bus.error !== 1'b0)
            $display("[TB] FAIL b2b_first: data %h error %b done %b, expected 1111/0/1", bus.data, bus.error, gotDone);
        else passCount++;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL b2b_busy_at_done: got %b expected 0", bus.busy); else passCount++;
        @(negedge clock);
        logBase = stepLog.size();
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL b2b_start_on_done: busy %b expected 0 (start ignored)", bus.busy); else passCount++;
        @(negedge clock);
        checkCount++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_restart: busy %b expected 1", bus.busy); else passCount++;
        waitDone(gotDone);
        bus.start = 1'b0;
        checkCount++;
        if (!gotDone || bus.data !== 16'h1111) $display("[TB] FAIL b2b_second: data %h done %b expected 1111/1", bus.data, gotDone); else passCount++;
        bad = firstSeqMismatch(6'h17, 0);
        checkCount++;
        if (bad !== -1) $display("[TB] FAIL b2b_seq: step %0d got %h expected %h", bad, stepLog[logBase + bad], expectedStep(bad, 6'h17, 0)); else passCount++;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        bit seen;
        bus.reg_addr = 6'h0A;
        bus.icap_o   = 16'h7DF7;
        busyLeft     = 0;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.icap_i === 16'h9482) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkCount++;
        if (!seen) $display("[TB] FAIL mid_rdhdr_seen: icap_i %h, expected 9482 within bound", bus.icap_i); else passCount++;
        monEn = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkCount++;
        if ({bus.busy, bus.done, bus.error} !== 3'b000) $display("[TB] FAIL mid_status: got %b expected 000", {bus.busy, bus.done, bus.error}); else passCount++;
        checkCount++;
        if (bus.data !== 16'h0000) $display("[TB] FAIL mid_data: got %h expected 0000", bus.data); else passCount++;
        checkCount++;
        if ({bus.icap_ce, bus.icap_write, bus.icap_i, bus.icap_clk} !== {2'b11, 16'hFFFF, 1'b0})
            $display("[TB] FAIL mid_icap: got %b %b %h %b expected 1 1 ffff 0", bus.icap_ce, bus.icap_write, bus.icap_i, bus.icap_clk);
        else passCount++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        monEn = 1'b1;
    endtask

    task automatic test_fresh_after_reset;
        applyStimulus(6'h0A, 16'h7DF7, 0);
        checkCount++;
        if (!gotDone || doneData !== 16'hBEEF || doneError !== 1'b0)
            $display("[TB] FAIL fresh_read: data %h error %b done %b expected beef/0/1", doneData, doneError, gotDone);
        else passCount++;
        bad = firstSeqMismatch(6'h0A, 0);
        checkCount++;
        if (bad !== -1) $display("[TB] FAIL fresh_seq: step %0d got %h expected %h", bad, stepLog[logBase + bad], expectedStep(bad, 6'h0A, 0)); else passCount++;
    endtask

    // Test sequence
    initial begin
        checkCount   = 0;
        passCount    = 0;
        busyLeft     = 0;
        logBase      = 0;
        monEn        = 1'b0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.reg_addr = '0;
        bus.icap_o   = '0;
        repeat (4) @(negedge clock);
        test_reset;
        reset = 1'b0;
        @(negedge clock);
        monEn = 1'b1;
        test_basic_read;
        test_bit_reversal;
        test_busy_wait;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_fresh_after_reset;
        repeat (4) @(negedge clock);
        checkCount += monChecks;
        passCount  += monPasses;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
